dds_phase_acc_mc: RTL and testbench
===================================

# dds_phase_acc_mc

Multi-channel, parametrised DDS phase accumulator: the next generation of the single-channel divider-based phase counter. Each channel accumulates a full-width frequency tuning word (FTW) modulo 2^ACC_W and adds a per-channel phase offset. Each channel presents a truncated phase word to the downstream waveform LUT. A valid/ready config port loads FTW and offset per channel, either immediately or phase-continuously (deferred to the next wrap).

## Interface
- ACC_W, 16: accumulator and FTW/offset width, 8..32
- OUT_W, 8: phase output width, top OUT_W bits of the sum, OUT_W <= ACC_W
- CH, 4: channel count, 1..16
- CH_W, $clog2(CH) (min 1): channel index width
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  global advance; low = all accumulators hold
- sync  in  CH  per-channel synchronous phase clear
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept; combinational = !pending[cfg_ch]
- cfg_ch  in  CH_W  target channel; values >= CH are accepted and ignored
- cfg_sel  in  1  0 = FTW, 1 = phase offset
- cfg_mode  in  1  FTW only: 0 = immediate, 1 = deferred to wrap
- cfg_data  in  ACC_W  FTW or offset value
- phase_out  out  CH*OUT_W  channel i at bits [i*OUT_W +: OUT_W]
- wrap  out  CH  one-cycle pulse per accumulator carry-out
- pending  out  CH  deferred FTW waiting for commit

## Operation
- Per channel state: acc, ftw, poff, shadow (all ACC_W), pending, wrap, phase_out.
- Transfer occurs on a rising edge with cfg_valid && cfg_ready.
  - sel=1: poff written. Always immediate.
  - sel=0, mode=0: ftw written.
  - sel=0, mode=1: shadow written and pending set.
- Accumulate: when enable=1, acc <= acc + ftw, truncated to ACC_W. The carry-out sets wrap for exactly one cycle.
- Commit: on a cycle with a carry-out, or with sync[i]=1, if pending[i] then ftw <= shadow and pending clears. The new ftw applies from the following edge's add.
- sync[i]=1: acc <= 0 regardless of enable. It takes priority over accumulate. It suppresses wrap[i] that cycle. It commits pending as above.
- enable=0: no add, no wrap, no wrap-triggered commit. Sync and config still act.
- ftw=0 is legal: acc frozen, no wrap. Any pending shadow then commits only via sync.
- Phase output: phase_out[i] <= top OUT_W bits of (acc + poff) mod 2^ACC_W, using pre-edge register values.
- While pending[i]=1, cfg_ready is low whenever cfg_ch=i, including for offset writes. The master holds the request until the commit.

## Timing
- Reset (async assert, sync deassert expected): acc, ftw, poff, shadow = 0; pending = 0; wrap = 0; phase_out = 0. cfg_ready = 1 once reset is low.
- Config accepted at edge k:
  - The new ftw is first added at edge k+1.
  - The new poff is reflected in phase_out at edge k+1.
- Phase_out lags acc by one cycle. wrap asserts at the same edge acc wraps.
- Deferred commit at wrap edge w: pending drops at w, and cfg_ready for that channel returns high after w. The new ftw is added at w+1.
- No combinational path from inputs to outputs except cfg_ready, which depends on cfg_ch.

## Test plan
- **Immediate FTW.** Defaults; reset; write ch0 FTW 0x0100, mode 0; enable=1.
  - acc0 steps 0x0100, 0x0200, …; phase_out0 lags by one cycle (0x01, 0x02, …).
  - acc0 returns to 0x0000 at cycle 256 with wrap[0] high for one cycle only.
- **Deferred FTW.** ch1 running FTW 0x4000; at acc1=0x4000, write FTW 0x8000 with mode 1.
  - pending[1]=1 and cfg_ready=0 for cfg_ch=1.
  - acc1 goes 0x8000, 0xC000, 0x0000; wrap and commit occur on the 0x0000 edge.
  - acc1 then goes 0x8000, 0x0000; pending[1]=0.
- **Phase offset.** ch2 FTW 0; write poff 0x8000.
  - phase_out2 = 0x80 from the next edge; acc2 stays 0; wrap[2] never asserts.
- **Sync collision.** ch3 acc=0xF000, FTW 0x2000, pending shadow 0x0400; assert sync[3] on the carry cycle.
  - acc3=0, wrap[3]=0, ftw=0x0400, pending cleared; next acc3=0x0400.
- **Enable low.** Hold enable=0 for 10 cycles with a pending shadow.
  - All acc hold, pending stays set, no wrap.
  - An immediate write to another channel is accepted.
- **Async reset.** Assert reset mid-run between clock edges.
  - All phase_out, wrap and pending read 0 before the next edge.
  - After release, cfg_ready=1 and acc begins at 0.

Source files
------------

// File: rtl/dds_phase_acc_mc.sv
// Multi-channel DDS phase accumulator with per-channel FTW, phase offset and
// phase-continuous (wrap-deferred) FTW updates through a valid/ready config port.
module dds_phase_acc_mc #(
    parameter int ACC_W = 16,
    parameter int OUT_W = 8,
    parameter int CH    = 4,
    parameter int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [CH-1:0]       sync,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic                cfg_sel,
    input  logic                cfg_mode,
    input  logic [ACC_W-1:0]    cfg_data,
    output logic [CH*OUT_W-1:0] phase_out,
    output logic [CH-1:0]       wrap,
    output logic [CH-1:0]       pending
);

    // Phase word for the LUT: top OUT_W bits of (acc + offset) mod 2^ACC_W.
    function automatic logic [OUT_W-1:0] phase_trunc(input logic [ACC_W-1:0] acc,
                                                     input logic [ACC_W-1:0] off);
        logic [ACC_W-1:0] sum;
        sum = acc + off;
        return OUT_W'(sum >> (ACC_W - OUT_W));
    endfunction

    logic cfg_fire;

    // A channel with a deferred FTW outstanding refuses every write until it commits;
    // out-of-range channel indices always accept and are dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int c = 0; c < CH; c++) begin
            if (cfg_ch == CH_W'(c) && pending[c]) begin
                cfg_ready = 1'b0;
            end
        end
    end

    assign cfg_fire = cfg_valid && cfg_ready;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [ACC_W-1:0] acc_p0;
        logic [ACC_W-1:0] ftw;
        logic [ACC_W-1:0] poff;
        logic [ACC_W-1:0] shadow;
        logic             pend_q;
        logic             wrap_p0;
        logic [OUT_W-1:0] phase_p1;
        logic [ACC_W:0]   sum;
        logic             hit;
        logic             carry;
        logic             commit;

        assign hit    = cfg_fire && (cfg_ch == CH_W'(i));
        assign sum    = {1'b0, acc_p0} + {1'b0, ftw};
        assign carry  = enable && sum[ACC_W];
        assign commit = pend_q && (sync[i] || carry);

        // Stage p0: accumulator and carry-out pulse; sync clears and masks the wrap.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                acc_p0  <= '0;
                wrap_p0 <= 1'b0;
            end else begin
                if (sync[i]) begin
                    acc_p0 <= '0;
                end else if (enable) begin
                    acc_p0 <= sum[ACC_W-1:0];
                end
                wrap_p0 <= carry && !sync[i];
            end
        end

        // Stage p1: offset phase, one cycle behind the accumulator.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                phase_p1 <= '0;
            end else begin
                phase_p1 <= phase_trunc(acc_p0, poff);
            end
        end

        // Tuning state. commit needs pend_q and hit needs !pend_q, so they never collide.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ftw    <= '0;
                poff   <= '0;
                shadow <= '0;
                pend_q <= 1'b0;
            end else begin
                if (commit) begin
                    ftw    <= shadow;
                    pend_q <= 1'b0;
                end
                if (hit) begin
                    if (cfg_sel) begin
                        poff <= cfg_data;
                    end else if (cfg_mode) begin
                        shadow <= cfg_data;
                        pend_q <= 1'b1;
                    end else begin
                        ftw <= cfg_data;
                    end
                end
            end
        end

        assign phase_out[i*OUT_W +: OUT_W] = phase_p1;
        assign wrap[i]                     = wrap_p0;
        assign pending[i]                  = pend_q;
    end

endmodule

// File: tb/tb_dds_phase_acc_mc.sv
// Directed bench for dds_phase_acc_mc: a vector table for the config/deferred-commit
// flow, then hand sequences for the full 256-step wrap, async reset and sync collision.
module tb_dds_phase_acc_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  sync;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic        cfg_sel;
    logic        cfg_mode;
    logic [15:0] cfg_data;
    logic [31:0] phase_out;
    logic [3:0]  wrap;
    logic [3:0]  pending;

    int n_cmp  = 0;
    int n_miss = 0;

    dds_phase_acc_mc #(.ACC_W(16), .OUT_W(8), .CH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_sel   (cfg_sel),
        .cfg_mode  (cfg_mode),
        .cfg_data  (cfg_data),
        .phase_out (phase_out),
        .wrap      (wrap),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  sy;
        logic        v;
        logic [1:0]  ch;
        logic        sel;
        logic        mode;
        logic [15:0] data;
        logic        exp_rdy;
        logic [31:0] exp_ph;
        logic [3:0]  exp_wr;
        logic [3:0]  exp_pd;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(logic en, logic [3:0] sy, logic v, logic [1:0] ch,
                                logic sel, logic mode, logic [15:0] data, logic rdy,
                                logic [31:0] ph, logic [3:0] wr, logic [3:0] pd);
        vec_t r;
        r.en = en; r.sy = sy; r.v = v; r.ch = ch; r.sel = sel; r.mode = mode;
        r.data = data; r.exp_rdy = rdy; r.exp_ph = ph; r.exp_wr = wr; r.exp_pd = pd;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] sy, input logic v,
                         input logic [1:0] ch, input logic sel, input logic mode,
                         input logic [15:0] data);
        enable = en; sync = sy; cfg_valid = v; cfg_ch = ch;
        cfg_sel = sel; cfg_mode = mode; cfg_data = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ch1 deferred FTW + ch2 offset with zero FTW, then enable-low with a pending shadow.
        tbl[0]  = mk(0, 0, 1, 1, 0, 0, 16'h4000, 1, 32'h0000_0000, 4'b0000, 4'b0000);
        tbl[1]  = mk(0, 0, 1, 2, 1, 0, 16'h8000, 1, 32'h0000_0000, 4'b0000, 4'b0000);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 16'h0000, 1, 32'h0080_0000, 4'b0000, 4'b0000);
        tbl[3]  = mk(1, 0, 1, 1, 0, 1, 16'h8000, 1, 32'h0080_4000, 4'b0000, 4'b0010);
        tbl[4]  = mk(1, 0, 1, 1, 1, 0, 16'h1234, 0, 32'h0080_8000, 4'b0000, 4'b0010);
        tbl[5]  = mk(1, 0, 0, 1, 0, 0, 16'h0000, 0, 32'h0080_C000, 4'b0010, 4'b0000);
        tbl[6]  = mk(1, 0, 0, 1, 0, 0, 16'h0000, 1, 32'h0080_0000, 4'b0000, 4'b0000);
        tbl[7]  = mk(1, 0, 0, 1, 0, 0, 16'h0000, 1, 32'h0080_8000, 4'b0010, 4'b0000);
        tbl[8]  = mk(1, 0, 0, 1, 0, 0, 16'h0000, 1, 32'h0080_0000, 4'b0000, 4'b0000);
        tbl[9]  = mk(1, 0, 1, 1, 0, 1, 16'h2000, 1, 32'h0080_8000, 4'b0010, 4'b0010);
        tbl[10] = mk(0, 0, 1, 0, 0, 0, 16'h0100, 1, 32'h0080_0000, 4'b0000, 4'b0010);
        for (int k = 11; k < 20; k++)
            tbl[k] = mk(0, 0, 0, 1, 0, 0, 16'h0000, 0, 32'h0080_0000, 4'b0000, 4'b0010);
        tbl[20] = mk(1, 0, 0, 0, 0, 0, 16'h0000, 1, 32'h0080_0000, 4'b0000, 4'b0010);
        tbl[21] = mk(1, 0, 0, 1, 0, 0, 16'h0000, 0, 32'h0080_8001, 4'b0010, 4'b0000);
        tbl[22] = mk(1, 0, 0, 1, 0, 0, 16'h0000, 1, 32'h0080_0002, 4'b0000, 4'b0000);
        tbl[23] = mk(1, 0, 0, 0, 0, 0, 16'h0000, 1, 32'h0080_2003, 4'b0000, 4'b0000);
        tbl[24] = mk(1, 0, 1, 3, 0, 1, 16'h0400, 1, 32'h0080_4004, 4'b0000, 4'b1000);

        reset = 1'b1;
        drive(0, 4'b0, 0, 2'd0, 0, 0, 16'h0);
        #12;
        chk("reset phase_out", phase_out, 32'h0);
        chk("reset wrap", {28'h0, wrap}, 32'h0);
        chk("reset pending", {28'h0, pending}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset cfg_ready", {31'h0, cfg_ready}, 32'h1);

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].en, tbl[i].sy, tbl[i].v, tbl[i].ch, tbl[i].sel, tbl[i].mode, tbl[i].data);
            #1;
            chk($sformatf("row%0d cfg_ready", i), {31'h0, cfg_ready}, {31'h0, tbl[i].exp_rdy});
            tick();
            chk($sformatf("row%0d phase_out", i), phase_out, tbl[i].exp_ph);
            chk($sformatf("row%0d wrap", i), {28'h0, wrap}, {28'h0, tbl[i].exp_wr});
            chk($sformatf("row%0d pending", i), {28'h0, pending}, {28'h0, tbl[i].exp_pd});
        end

        // Async reset between edges, with ch3 pending and phase words nonzero.
        drive(1, 4'b0, 0, 2'd3, 0, 0, 16'h0);
        #3;
        reset = 1'b1;
        #1;
        chk("async phase_out", phase_out, 32'h0);
        chk("async wrap", {28'h0, wrap}, 32'h0);
        chk("async pending", {28'h0, pending}, 32'h0);
        drive(0, 4'b0, 0, 2'd3, 0, 0, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post-reset cfg_ready", {31'h0, cfg_ready}, 32'h1);

        // ch0 immediate FTW 0x0100: full 256-step cycle and single wrap pulse.
        drive(0, 4'b0, 1, 2'd0, 0, 0, 16'h0100);
        tick();
        chk("imm load phase_out", phase_out, 32'h0);
        drive(1, 4'b0, 0, 2'd0, 0, 0, 16'h0);
        for (int n = 1; n <= 258; n++) begin
            logic [7:0] e;
            e = 8'(n - 1);
            tick();
            chk($sformatf("imm step%0d phase_out", n), phase_out, {24'h0, e});
            chk($sformatf("imm step%0d wrap", n), {28'h0, wrap}, (n == 256) ? 32'h1 : 32'h0);
        end

        // ch3 sync on the carry cycle with a pending shadow.
        reset = 1'b1;
        drive(0, 4'b0, 0, 2'd0, 0, 0, 16'h0);
        tick();
        @(negedge clk);
        reset = 1'b0;
        drive(0, 4'b0, 1, 2'd3, 0, 0, 16'h1000);
        tick();
        drive(1, 4'b0, 0, 2'd3, 0, 0, 16'h0);
        repeat (14) tick();
        chk("sync ramp phase_out", phase_out, 32'hD000_0000);
        drive(1, 4'b0, 1, 2'd3, 0, 0, 16'h2000);
        tick();
        chk("sync ftw2000 phase_out", phase_out, 32'hE000_0000);
        drive(0, 4'b0, 1, 2'd3, 0, 1, 16'h0400);
        #1;
        chk("sync defer cfg_ready", {31'h0, cfg_ready}, 32'h1);
        tick();
        chk("sync defer pending", {28'h0, pending}, 32'h8);
        chk("sync defer phase_out", phase_out, 32'hF000_0000);
        drive(1, 4'b1000, 0, 2'd3, 0, 0, 16'h0);
        #1;
        chk("sync blocked cfg_ready", {31'h0, cfg_ready}, 32'h0);
        tick();
        chk("sync edge wrap", {28'h0, wrap}, 32'h0);
        chk("sync edge pending", {28'h0, pending}, 32'h0);
        chk("sync edge phase_out", phase_out, 32'hF000_0000);
        drive(1, 4'b0, 0, 2'd3, 0, 0, 16'h0);
        tick();
        chk("sync after1 phase_out", phase_out, 32'h0);
        tick();
        chk("sync after2 phase_out", phase_out, 32'h0400_0000);
        tick();
        chk("sync after3 phase_out", phase_out, 32'h0800_0000);
        chk("sync after3 wrap", {28'h0, wrap}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule
